io_switch_led_responder: RTL and testbench
==========================================

IO_SWITCH_LED_RESPONDER -- requirements
Module: io_switch_led_responder

Interface
- REQ-001 SHALL have parameter DEB_CYCLES, default 16: number of consecutive stable cycles needed to accept a new switch value (legal range 2..1024).
- REQ-002 SHALL have parameter IO_BASE, default 32'hFFFFFC00: base of the IO window.
- REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
- REQ-005 SHALL have port io_read, input, 1: single-cycle IO read strobe from the memory/IO arbiter.
- REQ-006 SHALL have port io_write, input, 1: single-cycle IO write strobe from the memory/IO arbiter.
- REQ-007 SHALL have port addr, input, 32: byte address of the access.
- REQ-008 SHALL have port write_data, input, 16: IO write data.
- REQ-009 SHALL have port io_rdata, output, 16: registered read data.
- REQ-010 SHALL have port io_ready, output, 1: one-cycle completion pulse for every accepted strobe.
- REQ-011 SHALL have port switch, input, 16: raw asynchronous board switches.
- REQ-012 SHALL have port led, output, 16: LED register value.

Function
- REQ-013 SHALL map the following addresses. IO_BASE+0x60 is LED (read/write). IO_BASE+0x70 is debounced switches (read-only). IO_BASE+0x72 is the change flag (read-to-clear, returned as {15'b0, flag}).
- REQ-014 SHALL treat an odd addr, or any other address, as unmapped. A read of it returns 16'h0000; a write to it is ignored.
- REQ-015 SHALL, on io_write to LED, load led with write_data at that edge; led is visible the cycle after the strobe.
- REQ-016 SHALL, on io_read, load io_rdata at that edge with the selected value; io_rdata is valid the cycle after the strobe and holds until the next read.
- REQ-017 SHALL pulse io_ready high for exactly one cycle, the cycle after any io_read or io_write, whether the address is mapped or not.
- REQ-018 SHALL give io_write priority when io_read and io_write are both high: only the write is performed, io_rdata is unchanged, and io_ready pulses once.
- REQ-019 SHALL accept back-to-back strobes in consecutive cycles with no stall; each produces its own io_ready pulse.
- REQ-020 SHALL pass switch through a 2-flop synchronizer (sync1, sync2) before any use.
- REQ-021 SHALL debounce using registers cand[15:0] and cnt. When sync2≠cand: cand←sync2 and cnt←0. When sync2=cand and cnt<DEB_CYCLES-1: cnt←cnt+1. When sync2=cand and cnt=DEB_CYCLES-1: sw_stable←cand and cnt holds (saturates).
- REQ-022 SHALL make a switch change held steady visible in sw_stable exactly DEB_CYCLES+3 rising edges after it first meets the sync1 setup window.
- REQ-023 SHALL reset cnt on any glitch shorter than DEB_CYCLES cycles, leaving sw_stable unchanged.
- REQ-024 SHALL set flag when sw_stable loads a value different from its previous value.
- REQ-025 SHALL clear flag on a read of IO_BASE+0x72; that read returns the pre-clear flag value.
- REQ-026 SHALL keep flag at 1 when a set event and a clearing read occur in the same cycle (set wins).
- REQ-027 SHALL have a switch-register read return sw_stable as of the strobe edge; a same-cycle sw_stable update is not returned.

Reset
- REQ-028 SHALL, while reset is high at a clock edge, clear led, io_rdata, io_ready, sync1, sync2, cand, cnt, sw_stable and flag to 0.
- REQ-029 SHALL ignore io_read and io_write strobes coinciding with reset: no state change and no io_ready.
- REQ-030 SHALL, when reset is asserted mid-debounce, discard the partial count; debouncing restarts from cand=0, cnt=0 after reset is released.

Verification
- REQ-031 SHALL cover LED write/readback: write 0xA5C3 to IO_BASE+0x60, then read it. Required: led=0xA5C3 one cycle after the write; io_rdata=0xA5C3 and io_ready=1 one cycle after the read.
- REQ-032 SHALL cover debounce latency: with DEB_CYCLES=16, step switch 0x0000→0x00FF and hold. Required: sw_stable=0x00FF exactly 19 edges later, flag=1, and a read of +0x70 returns 0x00FF.
- REQ-033 SHALL cover glitch rejection: pulse switch to 0x0001 for 10 cycles, then return it to 0x0000. Required: sw_stable stays 0x0000 and flag stays 0.
- REQ-034 SHALL cover flag clear and the same-cycle set/clear race. Required: the first read of +0x72 returns 0x0001 and the next returns 0x0000. Required when the read coincides with a sw_stable change: returns 0x0001 and flag stays 1.
- REQ-035 SHALL cover simultaneous strobes and unmapped accesses. io_read and io_write high together at +0x60 with data 0x1234: led=0x1234, io_rdata unchanged, one io_ready pulse. Read of IO_BASE+0x10: io_rdata=0x0000 with io_ready pulsed.
- REQ-036 SHALL cover reset during activity: assert reset during a write strobe and mid-debounce. Required: led=0, no io_ready, and sw_stable updates only DEB_CYCLES+3 edges after release.

Source files
------------

// File: rtl/io_switch_led_responder.sv
// io_switch_led_responder: IO-mapped LED register (+0x60), debounced switches (+0x70), read-to-clear change flag (+0x72); ports clock/reset, io_read/io_write/addr/write_data -> io_rdata/io_ready, switch -> led
module io_switch_led_responder #(
  parameter int          DEB_CYCLES = 16,
  parameter logic [31:0] IO_BASE    = 32'hFFFFFC00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [31:0] addr,
  input  logic [15:0] write_data,
  output logic [15:0] io_rdata,
  output logic        io_ready,
  input  logic [15:0] switch,
  output logic [15:0] led
);
  localparam int CW = $clog2(DEB_CYCLES);
  logic [15:0] led_q, led_d, rdata_q, rdata_d, sync1_q, sync1_d, sync2_q, sync2_d;
  logic [15:0] cand_q, cand_d, sw_q, sw_d, rsel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ready_q, ready_d, flag_q, flag_d;
  logic rd, sel_led, sel_sw, sel_flag, same, sat;
  always_comb begin
    rd       = io_read & ~io_write;
    sel_led  = ~addr[0] && addr == IO_BASE + 32'h60;
    sel_sw   = ~addr[0] && addr == IO_BASE + 32'h70;
    sel_flag = ~addr[0] && addr == IO_BASE + 32'h72;
    led_d    = io_write && sel_led ? write_data : led_q;
    rsel     = sel_led ? led_q : sel_sw ? sw_q : sel_flag ? {15'b0, flag_q} : 16'h0000;
    rdata_d  = rd ? rsel : rdata_q;
    ready_d  = io_read | io_write;
    sync1_d  = switch;
    sync2_d  = sync1_q;
    same     = sync2_q == cand_q;
    sat      = cnt_q == CW'(DEB_CYCLES - 1);
    cand_d   = sync2_q;
    cnt_d    = !same ? '0 : sat ? cnt_q : cnt_q + 1'b1;
    sw_d     = same && sat ? cand_q : sw_q;
    flag_d   = (sw_d != sw_q) | (flag_q & ~(rd & sel_flag));
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      led_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      sw_q    <= '0;
      flag_q  <= 1'b0;
    end else begin
      led_q   <= led_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      flag_q  <= flag_d;
    end
  end
  assign led      = led_q;
  assign io_rdata = rdata_q;
  assign io_ready = ready_q;
endmodule

// File: tb/tb_io_switch_led_responder.sv
// tb_io_switch_led_responder: directed self-checking bench for io_switch_led_responder
module tb_io_switch_led_responder;
  localparam logic [31:0] A_LED  = 32'hFFFFFC60;
  localparam logic [31:0] A_SW   = 32'hFFFFFC70;
  localparam logic [31:0] A_FLAG = 32'hFFFFFC72;
  logic clock = 1'b0, reset = 1'b1, io_read = 1'b0, io_write = 1'b0, io_ready;
  logic [31:0] addr = '0;
  logic [15:0] write_data = '0, io_rdata, switch = '0, led;
  int checks = 0, failures = 0;
  io_switch_led_responder #(.DEB_CYCLES(16), .IO_BASE(32'hFFFFFC00)) dut (
    .clock(clock), .reset(reset), .io_read(io_read), .io_write(io_write), .addr(addr),
    .write_data(write_data), .io_rdata(io_rdata), .io_ready(io_ready), .switch(switch), .led(led)
  );
  always #5 clock = ~clock;
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [15:0] d);
    io_read = r;
    io_write = w;
    addr = a;
    write_data = d;
  endtask
  task automatic idle();
    drive(1'b0, 1'b0, '0, '0);
  endtask
  initial begin
    tick(3);
    reset = 1'b0;
    chk("reset_led", led, 16'h0000);
    chk("reset_rdata", io_rdata, 16'h0000);
    chk("reset_ready", {15'b0, io_ready}, 16'h0000);
    drive(1'b0, 1'b1, A_LED, 16'hA5C3);
    tick();
    chk("led_write", led, 16'hA5C3);
    chk("led_write_ready", {15'b0, io_ready}, 16'h0001);
    drive(1'b1, 1'b0, A_LED, '0);
    tick();
    chk("led_read", io_rdata, 16'hA5C3);
    chk("led_read_ready", {15'b0, io_ready}, 16'h0001);
    idle();
    tick();
    chk("ready_one_cycle", {15'b0, io_ready}, 16'h0000);
    chk("rdata_hold", io_rdata, 16'hA5C3);
    switch = 16'h0001;
    tick(10);
    switch = 16'h0000;
    tick(40);
    drive(1'b1, 1'b0, A_SW, '0);
    tick();
    chk("glitch_sw", io_rdata, 16'h0000);
    drive(1'b1, 1'b0, A_FLAG, '0);
    tick();
    chk("glitch_flag", io_rdata, 16'h0000);
    drive(1'b1, 1'b0, A_SW, '0);
    switch = 16'h00FF;
    tick(18);
    chk("deb_edge18", io_rdata, 16'h0000);
    tick();
    chk("deb_edge19_pre", io_rdata, 16'h0000);
    tick();
    chk("deb_edge20_new", io_rdata, 16'h00FF);
    chk("b2b_ready", {15'b0, io_ready}, 16'h0001);
    idle();
    switch = 16'h0F0F;
    tick(18);
    drive(1'b1, 1'b0, A_FLAG, '0);
    tick();
    chk("race_read", io_rdata, 16'h0001);
    drive(1'b1, 1'b0, A_SW, '0);
    tick();
    chk("race_sw", io_rdata, 16'h0F0F);
    drive(1'b1, 1'b0, A_FLAG, '0);
    tick();
    chk("race_flag_kept", io_rdata, 16'h0001);
    tick();
    chk("flag_cleared", io_rdata, 16'h0000);
    drive(1'b1, 1'b0, A_SW, '0);
    tick();
    chk("sw_before_sim", io_rdata, 16'h0F0F);
    drive(1'b1, 1'b1, A_LED, 16'h1234);
    tick();
    chk("sim_led", led, 16'h1234);
    chk("sim_rdata", io_rdata, 16'h0F0F);
    chk("sim_ready", {15'b0, io_ready}, 16'h0001);
    idle();
    tick();
    chk("sim_ready_once", {15'b0, io_ready}, 16'h0000);
    drive(1'b1, 1'b0, 32'hFFFFFC10, '0);
    tick();
    chk("unmapped_rdata", io_rdata, 16'h0000);
    chk("unmapped_ready", {15'b0, io_ready}, 16'h0001);
    drive(1'b1, 1'b0, A_LED, '0);
    tick();
    drive(1'b1, 1'b0, 32'hFFFFFC61, '0);
    tick();
    chk("odd_rdata", io_rdata, 16'h0000);
    drive(1'b0, 1'b1, 32'hFFFFFC62, 16'hFFFF);
    tick();
    chk("unmapped_write", led, 16'h1234);
    idle();
    switch = 16'h00AA;
    tick(5);
    reset = 1'b1;
    drive(1'b0, 1'b1, A_LED, 16'hBEEF);
    tick();
    chk("rst_led", led, 16'h0000);
    chk("rst_ready", {15'b0, io_ready}, 16'h0000);
    reset = 1'b0;
    drive(1'b1, 1'b0, A_SW, '0);
    tick(19);
    chk("rst_deb_edge19_pre", io_rdata, 16'h0000);
    tick();
    chk("rst_deb_edge20_new", io_rdata, 16'h00AA);
    idle();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
